// File: rtl/score_display_scanner_pkg.sv
// Shared types and constants for the score display scanner: FSM states, widths,
// active-low seven-segment patterns ({g,f,e,d,c,b,a}) and the add-3 step.
package score_disp_pkg;

  typedef enum logic {IDLE, CONVERT} state_t;

  localparam int BCD_DIGITS = 4;
  localparam int SCORE_W    = 14;
  localparam int CONV_ITERS = 14;
  localparam int BCD_W      = BCD_DIGITS * 4;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Double-dabble correction: any nibble >= 5 gets +3 before the next shift.
  function automatic logic [BCD_W-1:0] bcd_add3(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (b[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/score_display_scanner_bcd_to_seg.sv
// Combinational BCD digit to active-low seven-segment decoder; 10-15 blank.
module bcd_to_seg
  import score_disp_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/score_display_scanner.sv
// Score to 4-digit BCD (14-cycle double-dabble) plus multiplexed 7-seg scan.
// Define SCORE_DISPLAY_LEADING_ZERO_BLANK_EN to darken leading-zero digits.
module score_display_scanner
  import score_disp_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int SCORE_MAX   = 9999
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SCORE_W-1:0]  score_in,
  input  logic                score_load,
  output logic                busy,
  output logic                done,
  output logic [BCD_W-1:0]    digits,
  output logic [3:0]          an,
  output logic [6:0]          seg
);

  localparam int                 RC_W  = $clog2(REFRESH_DIV);
  localparam int                 SH_W  = BCD_W + SCORE_W;
  localparam logic [SCORE_W-1:0] MAX_V = SCORE_W'(SCORE_MAX);

  state_t             r_state;
  logic [SH_W-1:0]    r_shift;
  logic [3:0]         r_iter;
  logic               r_busy;
  logic               r_done;
  logic [BCD_W-1:0]   r_digits;
  logic [RC_W-1:0]    r_refresh_cnt;
  logic [1:0]         r_scan_idx;

  logic [SCORE_W-1:0] w_clamped;
  logic [SH_W-1:0]    w_step;
  logic [3:0]         w_nibble;
  logic [3:0]         w_an_scan;

  assign w_clamped = (score_in > MAX_V) ? MAX_V : score_in;
  assign w_step    = {bcd_add3(r_shift[SH_W-1:SCORE_W]), r_shift[SCORE_W-1:0]} << 1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_shift  <= '0;
      r_iter   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_digits <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (score_load) begin
            r_shift <= {{BCD_W{1'b0}}, w_clamped};
            r_iter  <= '0;
            r_busy  <= 1'b1;
            r_state <= CONVERT;
          end
        end
        CONVERT: begin
          r_shift <= w_step;
          r_iter  <= r_iter + 4'd1;
          if (r_iter == 4'(CONV_ITERS - 1)) begin
            r_digits <= w_step[SH_W-1:SCORE_W];
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= IDLE;
          end
        end
      endcase
    end
  end

  // Refresh timer and anode index run freely, independent of conversions.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_refresh_cnt <= '0;
      r_scan_idx    <= 2'd0;
    end else if (r_refresh_cnt == RC_W'(REFRESH_DIV - 1)) begin
      r_refresh_cnt <= '0;
      r_scan_idx    <= r_scan_idx + 2'd1;
    end else begin
      r_refresh_cnt <= r_refresh_cnt + 1'b1;
    end
  end

  assign w_nibble  = r_digits[{r_scan_idx, 2'b00} +: 4];
  assign w_an_scan = ~(4'b0001 << r_scan_idx);

`ifdef SCORE_DISPLAY_LEADING_ZERO_BLANK_EN
  logic [3:0] w_lead_zero;
  assign w_lead_zero[3] = (r_digits[15:12] == 4'd0);
  assign w_lead_zero[2] = w_lead_zero[3] && (r_digits[11:8] == 4'd0);
  assign w_lead_zero[1] = w_lead_zero[2] && (r_digits[7:4] == 4'd0);
  assign w_lead_zero[0] = 1'b0;
  assign an = w_lead_zero[r_scan_idx] ? 4'b1111 : w_an_scan;
`else
  assign an = w_an_scan;
`endif

  bcd_to_seg u_bcd_to_seg (
    .i_bcd (w_nibble),
    .o_seg (seg)
  );

  assign busy   = r_busy;
  assign done   = r_done;
  assign digits = r_digits;

endmodule

// File: doc/score_display_scanner.md
Name: score_display_scanner

Overview:
- Sequential controller that turns a 14-bit game score into four decimal digits and drives the 4-digit seven-segment display.
- Latches a score on request and converts it with an iterative shift-add-3 (double-dabble) routine, one iteration per clock.
- Time-multiplexes the display anodes at a programmable refresh rate.
- Sits between the score/game FSM and the board's seven-segment pins.

Parameters:
- REFRESH_DIV, 100000, clk cycles each digit stays lit (1 ms at 100 MHz); legal range 2 or more.
- SCORE_MAX, 9999, clamp ceiling applied to score_in before conversion.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- score_in  input  14  unsigned score; sampled only on an accepted load.
- score_load  input  1  single-cycle load request.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when new digits are committed.
- digits  output  16  committed BCD: [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] ones.
- an  output  4  anodes, active-low, one-hot-low; an[0] = ones.
- seg  output  7  cathodes, active-low, order {g,f,e,d,c,b,a}.

Behaviour:
- Clocking and reset:
  - One clock domain; reset is synchronous and active-high; all state is updated on the rising edge of clk.
  - Reset values: busy=0, done=0, digits=16'h0000, an=4'b1110, seg=7'b1000000 (shows "0"), refresh counter=0, scan index=0, FSM=IDLE.
- FSM states: IDLE, CONVERT.
- IDLE:
  - score_load=1 clamps the input: v = (score_in > SCORE_MAX) ? SCORE_MAX : score_in.
  - The shift register is loaded with {16'b0, v}, the iteration count is cleared, and the FSM moves to CONVERT.
- CONVERT, each cycle:
  - Every BCD nibble >= 5 gets +3.
  - The 30-bit register then shifts left by 1 and the count increments.
  - After the 14th iteration, digits is written atomically from the upper 16 bits, done pulses for one cycle, busy returns to 0, and the FSM returns to IDLE.
- Latency and timing:
  - If load is sampled at edge E0, busy=1 from E0 through the cycle before E14.
  - digits is updated and done=1 at edge E14, for exactly one cycle.
  - Back-to-back loads: a load in the same cycle as the done pulse is accepted; busy rises again the following cycle.
- Load while busy: ignored and dropped; the conversion in progress is unaffected and no error is flagged.
- Arithmetic: all add-3 operations are 4-bit and cannot overflow given the clamp. Score 0 gives digits 0000; score 16383 clamps to 9999.
- Display scan:
  - A free-running refresh counter runs 0..REFRESH_DIV-1.
  - On wrap, the scan index advances 0->1->2->3->0.
  - an = ~(4'b0001 << index). seg decodes digits[index*4 +: 4], which is always the committed value, so digits do not change mid-conversion.
  - Nibble values 10-15 cannot occur; if they did, the decoder would output 7'b1111111.
- Reset mid-conversion: the conversion is aborted, all reset values apply, and no done pulse is produced.

Optional Feature:
- Macro: SCORE_DISPLAY_LEADING_ZERO_BLANK_EN.
- Defined:
  - While the scan index selects a leading-zero digit, an=4'b1111: thousands if 0; hundreds if thousands and hundreds are 0; tens if the upper three are all 0.
  - Ones is never blanked.
  - seg is still driven normally, and scan timing is unchanged.
- Undefined: all four digits are always lit, including leading zeros.

Decomposition:
- Shared package score_disp_pkg holds:
  - the state enum {IDLE, CONVERT};
  - BCD_DIGITS=4, SCORE_W=14, CONV_ITERS=14;
  - the 7-bit seg constants for 0-9 and SEG_BLANK=7'b1111111.
- One sub-module is natural: bcd_to_seg, a combinational 4-bit BCD to 7-bit active-low decoder instanced once on the scan mux output.

Test Plan:
- Reset, then hold idle with REFRESH_DIV=4 -> busy=0, done=0, digits=0000; an cycles 1110, 1101, 1011, 0111, changing every 4 clk; seg=1000000 throughout.
- Load 1234 -> busy high for 14 cycles, done pulse at edge 14, digits=16'h1234; next scan shows seg for 4, 3, 2, 1 on an[0..3].
- Load 16383, then load 10000 -> both yield digits=16'h9999; load 0 -> digits=16'h0000 with done pulsed.
- Load 500, then load 42 at cycle 5 of that conversion -> the second load is dropped, digits=16'h0500, exactly one done pulse; load 42 in the done cycle -> accepted, digits=16'h0042 after 14 more cycles.
- Assert rst at cycle 7 of a conversion of 8888 -> no done pulse, digits=0000, busy=0, an=1110 on the next cycle.
- With SCORE_DISPLAY_LEADING_ZERO_BLANK_EN defined, load 7 -> an=1110 in slot 0 and 1111 in slots 1-3; load 1005 -> all four slots lit.
